// File: rtl/pool2x2_stream.sv
// 2x2 max/average pooling over a raster pixel stream; one result per 2x2 block, latency 1 cycle.
// No backpressure: in_valid low simply stalls all state, and the output side is a registered pulse.
module pool2x2_stream #(
    parameter int DATA_W   = 16,
    parameter int MAX_COLS = 32,
    parameter int ADDR_W   = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    input  logic                     frame_start_in,
    input  logic                     line_start_in,
    input  logic                     frame_end_in,
    input  logic signed [DATA_W-1:0] pix_in,
    input  logic                     mode,
    output logic signed [DATA_W-1:0] pix_out,
    output logic                     out_valid,
    output logic                     frame_start_out,
    output logic                     line_start_out,
    output logic                     frame_end_out,
    output logic                     col_err
);

    localparam int NPAIR = MAX_COLS / 2;
    localparam int CW0   = $clog2(MAX_COLS) + 1;
    localparam int CW    = (ADDR_W + 1 > CW0) ? ADDR_W + 1 : CW0;
    localparam logic [CW-1:0] COL_LIM = CW'(MAX_COLS);

    typedef enum logic [1:0] {
        IDLE,
        EVEN_ROW,
        ODD_ROW
    } state_t;

    state_t                   state_q, state_d, row_cur;
    logic [CW-1:0]            col_q, col_d, col_eff, half;
    logic                     mode_q, mode_d;
    logic signed [DATA_W-1:0] a_q, a_d;
    logic [NPAIR-1:0]         vld_q, vld_d;
    logic                     first_q, first_d;
    logic                     err_q, err_d;
    logic signed [DATA_W:0]   lb_q [NPAIR];

    logic signed [DATA_W-1:0] pix_q, pix_d;
    logic                     ov_q, ov_d;
    logic                     fso_q, fso_d;
    logic                     lso_q, lso_d;
    logic                     feo_q, feo_d;

    logic                     active, fs, ls, proc, in_range;
    logic                     pair_done, lb_wr, emit;
    logic [ADDR_W-1:0]        k;
    logic signed [DATA_W:0]   a_ext, b_ext, pair_res, lb_rd, max4;
    logic signed [DATA_W+1:0] sum4, avg4;
    logic signed [DATA_W-1:0] comb_res;

    always_comb begin
        active   = (state_q != IDLE);
        fs       = in_valid & frame_start_in;
        ls       = in_valid & line_start_in & active & ~frame_start_in;
        proc     = fs | (in_valid & active);
        col_eff  = (fs | ls) ? '0 : col_q;
        in_range = (col_eff < COL_LIM);
        half     = col_eff >> 1;
        k        = half[ADDR_W-1:0];

        // The row a pixel belongs to is the one entered by its own markers.
        if (fs) begin
            row_cur = EVEN_ROW;
        end else if (ls) begin
            row_cur = (state_q == EVEN_ROW) ? ODD_ROW : EVEN_ROW;
        end else begin
            row_cur = state_q;
        end

        a_ext = {a_q[DATA_W-1], a_q};
        b_ext = {pix_in[DATA_W-1], pix_in};
        if (mode_q) begin
            pair_res = a_ext + b_ext;
        end else begin
            pair_res = (a_ext > b_ext) ? a_ext : b_ext;
        end

        lb_rd = lb_q[k];
        sum4  = {lb_rd[DATA_W], lb_rd} + {pair_res[DATA_W], pair_res};
        avg4  = sum4 >>> 2;
        max4  = (lb_rd > pair_res) ? lb_rd : pair_res;
        comb_res = mode_q ? avg4[DATA_W-1:0] : max4[DATA_W-1:0];

        pair_done = proc & col_eff[0] & in_range;
        lb_wr     = pair_done & (row_cur == EVEN_ROW);
        // Only combine with entries written in the preceding even row of this frame.
        emit      = pair_done & (row_cur == ODD_ROW) & vld_q[k];
    end

    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        mode_d  = mode_q;
        a_d     = a_q;
        vld_d   = vld_q;
        first_d = first_q;
        err_d   = err_q;

        if (in_valid) begin
            if (fs) begin
                state_d = EVEN_ROW;
            end else if (active) begin
                state_d = frame_end_in ? IDLE : row_cur;
            end
        end

        if (proc) begin
            col_d = in_range ? col_eff + 1'b1 : col_eff;
        end

        if (fs) begin
            mode_d  = mode;
            err_d   = 1'b0;
            first_d = 1'b1;
        end else begin
            if (proc && !in_range) begin
                err_d = 1'b1;
            end
            if (emit) begin
                first_d = 1'b0;
            end
        end

        if (proc && !col_eff[0] && in_range) begin
            a_d = pix_in;
        end

        if (fs || (ls && state_q == ODD_ROW)) begin
            vld_d = '0;
        end
        if (lb_wr) begin
            vld_d[k] = 1'b1;
        end

        ov_d  = emit;
        pix_d = emit ? comb_res : pix_q;
        lso_d = emit & (k == '0);
        fso_d = emit & first_q;
        feo_d = in_valid & frame_end_in & ~frame_start_in & active;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            col_q   <= '0;
            mode_q  <= 1'b0;
            a_q     <= '0;
            vld_q   <= '0;
            first_q <= 1'b0;
            err_q   <= 1'b0;
            pix_q   <= '0;
            ov_q    <= 1'b0;
            fso_q   <= 1'b0;
            lso_q   <= 1'b0;
            feo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            mode_q  <= mode_d;
            a_q     <= a_d;
            vld_q   <= vld_d;
            first_q <= first_d;
            err_q   <= err_d;
            pix_q   <= pix_d;
            ov_q    <= ov_d;
            fso_q   <= fso_d;
            lso_q   <= lso_d;
            feo_q   <= feo_d;
        end
    end

    always_ff @(posedge clk) begin
        if (lb_wr) begin
            lb_q[k] <= pair_res;
        end
    end

    assign pix_out         = pix_q;
    assign out_valid       = ov_q;
    assign frame_start_out = fso_q;
    assign line_start_out  = lso_q;
    assign frame_end_out   = feo_q;
    assign col_err         = err_q;

endmodule

// File: tb/tb_pool2x2_stream.sv
// Directed bench for pool2x2_stream with a reference pooling model feeding an output scoreboard.
module tb_pool2x2_stream;

    localparam int DW = 16;
    localparam int MC = 4;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 in_valid, frame_start_in, line_start_in, frame_end_in, mode;
    logic signed [DW-1:0] pix_in, pix_out;
    logic                 out_valid, frame_start_out, line_start_out, frame_end_out, col_err;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    bit err_exp;

    typedef struct {
        logic v;
        logic fs;
        logic ls;
        logic fe;
        int   p;
        int   cyc;
    } ev_t;

    ev_t sb[$];
    ev_t mon_e;
    int  got[$];
    int  img[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    pool2x2_stream #(.DATA_W(DW), .MAX_COLS(MC), .ADDR_W(1)) dut (
        .clk            (clk),
        .rst            (rst),
        .in_valid       (in_valid),
        .frame_start_in (frame_start_in),
        .line_start_in  (line_start_in),
        .frame_end_in   (frame_end_in),
        .pix_in         (pix_in),
        .mode           (mode),
        .pix_out        (pix_out),
        .out_valid      (out_valid),
        .frame_start_out(frame_start_out),
        .line_start_out (line_start_out),
        .frame_end_out  (frame_end_out),
        .col_err        (col_err)
    );

    task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && (out_valid || frame_end_out || frame_start_out || line_start_out)) begin
            check("unexpected_output", sb.size() != 0, 1);
            if (sb.size() != 0) begin
                mon_e = sb.pop_front();
                check("out_valid", out_valid, mon_e.v);
                check("fs_ls_fe", {frame_start_out, line_start_out, frame_end_out},
                      {mon_e.fs, mon_e.ls, mon_e.fe});
                check("latency", cyc, mon_e.cyc);
                if (mon_e.v) begin
                    check("pix_out", pix_out, mon_e.p);
                    got.push_back(int'(pix_out));
                end
            end
        end
    end

    function automatic int pool(input int a, input int b, input int c, input int d, input bit md);
        int s;
        int m;
        if (md) begin
            s = a + b + c + d;
            return (s >= 0) ? s / 4 : -((3 - s) / 4);
        end
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            in_valid       = 1'b0;
            pix_in         = DW'($urandom);
            frame_start_in = 1'($urandom_range(0, 1));
            line_start_in  = 1'($urandom_range(0, 1));
            frame_end_in   = 1'($urandom_range(0, 1));
            mode           = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic px(input int p, input bit fs, input bit ls, input bit fe, input bit md);
        @(negedge clk);
        check("col_err", col_err, err_exp);
        in_valid       = 1'b1;
        pix_in         = DW'(p);
        frame_start_in = fs;
        line_start_in  = ls;
        frame_end_in   = fe;
        mode           = md;
        if (fs) err_exp = 1'b0;
    endtask

    // mode is driven inverted on every non-start pixel: only the start pixel may set it
    task automatic send_frame(input int rows, input int cols, input int im[$], input bit md, input int gap);
        bit   first;
        bit   fs;
        bit   last;
        ev_t  e;
        first = 1'b1;
        for (int r = 0; r < rows; r++) begin
            for (int c = 0; c < cols; c++) begin
                fs   = (r == 0 && c == 0);
                last = (r == rows - 1 && c == cols - 1);
                px(im[r*cols+c], fs, c == 0, last, fs ? md : ~md);
                if (c >= MC) err_exp = 1'b1;
                e.cyc = cyc + 1;
                if (r % 2 == 1 && c % 2 == 1 && c < MC) begin
                    e.v  = 1'b1;
                    e.fs = first;
                    e.ls = (c == 1);
                    e.fe = last;
                    e.p  = pool(im[(r-1)*cols+c-1], im[(r-1)*cols+c], im[r*cols+c-1], im[r*cols+c], md);
                    sb.push_back(e);
                    first = 1'b0;
                end else if (last) begin
                    e.v  = 1'b0;
                    e.fs = 1'b0;
                    e.ls = 1'b0;
                    e.fe = 1'b1;
                    e.p  = 0;
                    sb.push_back(e);
                end
                if (gap > 0) idle(gap);
            end
        end
        idle(2);
        check("col_err_end", col_err, err_exp);
    endtask

    task automatic check_got(input string tag, input int n, input int e0, input int e1, input int e2, input int e3);
        int ex[4];
        ex = '{e0, e1, e2, e3};
        check({tag, "_count"}, got.size(), n);
        for (int i = 0; i < n && i < got.size(); i++) begin
            check(tag, got[i], ex[i]);
        end
        got.delete();
    endtask

    task automatic set_seq(input int n);
        img.delete();
        for (int i = 1; i <= n; i++) img.push_back(i);
    endtask

    task automatic set4(input int a, input int b, input int c, input int d);
        img.delete();
        img.push_back(a);
        img.push_back(b);
        img.push_back(c);
        img.push_back(d);
    endtask

    initial begin
        rst            = 1'b1;
        in_valid       = 1'b0;
        frame_start_in = 1'b0;
        line_start_in  = 1'b0;
        frame_end_in   = 1'b0;
        pix_in         = '0;
        mode           = 1'b0;
        err_exp        = 1'b0;

        repeat (2) @(negedge clk);
        check("rst_pix_out", pix_out, 0);
        check("rst_flags", {out_valid, frame_start_out, line_start_out, frame_end_out, col_err}, 0);
        rst = 1'b0;
        idle(2);

        set_seq(16);
        send_frame(4, 4, img, 1'b0, 0);
        check_got("max4x4", 4, 6, 8, 14, 16);

        send_frame(4, 4, img, 1'b0, 2);
        check_got("max4x4_gaps", 4, 6, 8, 14, 16);

        set4(-1, -2, -3, -4);
        send_frame(2, 2, img, 1'b1, 0);
        check_got("avg_neg", 1, -3, 0, 0, 0);

        set4(1, 1, 1, 2);
        send_frame(2, 2, img, 1'b1, 1);
        check_got("avg_pos", 1, 1, 0, 0, 0);

        set_seq(12);
        send_frame(2, 6, img, 1'b0, 0);
        check_got("col_limit", 2, 8, 10, 0, 0);

        // frame A abandoned in its odd row, then frame B
        px(5, 1'b1, 1'b1, 1'b0, 1'b0);
        px(6, 1'b0, 1'b0, 1'b0, 1'b1);
        px(9, 1'b0, 1'b1, 1'b0, 1'b1);
        set4(7, 0, 0, 0);
        send_frame(2, 2, img, 1'b0, 0);
        check_got("abort", 1, 7, 0, 0, 0);

        px(3, 1'b1, 1'b1, 1'b0, 1'b1);
        px(4, 1'b0, 1'b0, 1'b0, 1'b0);
        px(5, 1'b0, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        rst      = 1'b1;
        @(negedge clk);
        check("mid_rst_pix_out", pix_out, 0);
        check("mid_rst_flags", {out_valid, frame_start_out, line_start_out, frame_end_out, col_err}, 0);
        rst = 1'b0;
        idle(2);
        set4(1, 1, 1, 2);
        send_frame(2, 2, img, 1'b1, 0);
        check_got("post_rst", 1, 1, 0, 0, 0);

        idle(3);
        check("sb_drained", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pool2x2_stream.md
POOL2X2_STREAM -- requirements
Module: pool2x2_stream

Interface
REQ-001 Parameter DATA_W, default 16, pixel width (signed two's complement).
REQ-002 Parameter MAX_COLS, default 32, maximum input pixels per line; must be even and >= 2.
REQ-003 Parameter ADDR_W, default 4, line-buffer address width; must satisfy 2**ADDR_W >= MAX_COLS/2.
REQ-004 clk  input  1  single clock; all state changes on the rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 in_valid  input  1  pix_in and the markers are valid this cycle.
REQ-007 frame_start_in  input  1  qualified by in_valid; marks the first pixel of a frame, which also starts a line.
REQ-008 line_start_in  input  1  qualified by in_valid; marks the first pixel of a line.
REQ-009 frame_end_in  input  1  qualified by in_valid; marks the last pixel of a frame.
REQ-010 pix_in  input  DATA_W  signed input pixel.
REQ-011 mode  input  1  0 = max pooling, 1 = average pooling; sampled only on a qualified frame_start_in.
REQ-012 pix_out  output  DATA_W  signed pooled result.
REQ-013 out_valid  output  1  pix_out is valid this cycle.
REQ-014 frame_start_out, line_start_out, frame_end_out  output  1 each  output-side marker pulses.
REQ-015 col_err  output  1  sticky flag: a line exceeded MAX_COLS.

Function
REQ-016 FSM states: IDLE, EVEN_ROW, ODD_ROW.
REQ-017 FSM transitions:
- IDLE -> EVEN_ROW on frame_start_in.
- EVEN_ROW -> ODD_ROW on line_start_in.
- ODD_ROW -> EVEN_ROW on line_start_in.
- any state -> IDLE on frame_end_in when frame_start_in is not also asserted.
REQ-018 A qualified frame_start_in in any state aborts the current frame without generating output, enters EVEN_ROW, clears col_err, latches mode, and the pixel that carries it is processed as column 0.
REQ-019 Column counter: cleared to 0 by a line_start or frame_start pixel; incremented by each subsequent qualified pixel.
REQ-020 Pixel pairs: columns 2k and 2k+1 form pair k; the pair result is max(a,b) in max mode and the sign-extended sum a+b (DATA_W+1 bits) in average mode.
REQ-021 EVEN_ROW: the pair result is written to line-buffer entry k on the cycle column 2k+1 is accepted; no output is produced.
REQ-022 ODD_ROW: on acceptance of column 2k+1, the pair result is combined with buffer entry k:
- max mode: the larger of the two values;
- average mode: the 4-pixel sum (DATA_W+2 bits) arithmetically shifted right by 2, i.e. floor division.
REQ-023 The combined result is registered: out_valid is high for exactly one cycle, the cycle after column 2k+1 is accepted (latency 1).
REQ-024 An unpaired trailing pixel (odd line length) is discarded.
REQ-025 Pixels at column >= MAX_COLS are discarded (no buffer write, no output) and set col_err, which holds until rst or the next frame_start_in.
REQ-026 in_valid low stalls the block: no counter, buffer or FSM change; gaps of any length between pixels are legal.
REQ-027 line_start_out is asserted together with out_valid for the pair k=0 output of every ODD_ROW.
REQ-028 frame_start_out is additionally asserted with the first out_valid of a frame.
REQ-029 frame_end_out timing:
- if the frame_end_in pixel completes an ODD_ROW pair, frame_end_out is asserted together with that output;
- otherwise it is a single pulse one cycle after frame_end_in, with out_valid = 0.
REQ-030 A line_start_in or frame_end_in pixel received in IDLE is ignored.
REQ-031 The line buffer holds MAX_COLS/2 entries of DATA_W+1 bits; it is inferred as registers or RAM, with read data available in the same cycle as column 2k+1.

Reset
REQ-032 While rst is high:
- FSM is in IDLE;
- column counter = 0;
- mode latch = 0;
- pix_out = 0, and all single-bit outputs = 0.
REQ-033 Line-buffer contents are not reset, and no output may depend on an unwritten entry.
REQ-034 rst asserted mid-frame takes effect immediately; the block then waits in IDLE for a frame_start_in.

Verification
REQ-035 Max mode, 4x4 frame with rows [1,2,3,4], [5,6,7,8], [9,10,11,12], [13,14,15,16]:
- outputs are 6, 8, 14, 16;
- line_start_out accompanies 6 and 14;
- frame_start_out accompanies 6;
- frame_end_out accompanies 16.
REQ-036 Average mode, 2x2 frame [-1,-2], [-3,-4]: the sum is -10 and pix_out = -3 (floor); also check [1,1], [1,2]: pix_out = 1.
REQ-037 Same 4x4 max frame with in_valid toggling 1,0,0,1,...: identical outputs, each exactly 1 cycle after its completing pixel.
REQ-038 MAX_COLS = 4 with a 6-pixel line: col_err rises on the 5th pixel, the extra pixels produce no output, and col_err clears on the next frame_start_in.
REQ-039 frame_start_in during ODD_ROW of frame A, then a full 2x2 frame B [7,0], [0,0] in max mode: no output from frame A; output 7 with frame_start_out, line_start_out and frame_end_out all high.
REQ-040 rst pulsed mid-row, followed by a clean 2x2 frame: no stale output, and correct results after reset.
